// File: rtl/lpm_norm_pkg.sv
// lpm_norm_pkg: shared types and sizing helper for the normalizer
package lpm_norm_pkg;

    typedef enum logic {LOGICAL, ARITHMETIC} norm_type_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} norm_state_t;

    function automatic int norm_stages(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/lpm_norm_stage.sv
// lpm_norm_stage: one binary-search step, tests the top s (or s+1) bits and shifts when redundant
module lpm_norm_stage
    import lpm_norm_pkg::*;
#(
    parameter int W  = 32,
    parameter int DW = 6
) (
    input  logic [W-1:0]  cur,
    input  logic [DW-1:0] s,
    input  norm_type_t    shifttype,
    output logic [W-1:0]  nxt,
    output logic          take
);

    localparam logic [W-1:0]  ONES = '1;
    localparam logic [DW-1:0] ONE  = 1;

    logic [W-1:0] lmask;
    logic [W-1:0] amask;

    // Arithmetic mode keeps one sign bit, so it inspects s+1 bits
    always_comb begin
        lmask = ~(ONES >> s);
        amask = ~(ONES >> (s + ONE));
        take  = (shifttype == ARITHMETIC) ? (((cur & amask) == '0) || ((cur & amask) == amask))
                                          : ((cur & lmask) == '0);
        nxt   = take ? cur << s : cur;
    end

endmodule

// File: rtl/lpm_normalize.sv
// lpm_normalize: multi-cycle normalizer returning the shifted word and its left-shift distance
module lpm_normalize
    import lpm_norm_pkg::*;
#(
    parameter int    lpm_width     = 32,
    parameter string lpm_shifttype = "LOGICAL",
    parameter int    lpm_widthdist = $clog2(lpm_width) + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [lpm_width-1:0]     data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [lpm_width-1:0]     result,
    output logic [lpm_widthdist-1:0] distance,
    output logic                     zero
);

    localparam int L  = norm_stages(lpm_width);
    localparam int SW = L;
    localparam norm_type_t ST = (lpm_shifttype == "ARITHMETIC") ? ARITHMETIC : LOGICAL;
    localparam logic [lpm_widthdist-1:0] WD = lpm_widthdist'(lpm_width);

    norm_state_t              state;
    logic [SW-1:0]            stage;
    logic [lpm_width-1:0]     cur;
    logic [lpm_width-1:0]     nxt;
    logic [lpm_widthdist-1:0] acc;
    logic [lpm_widthdist-1:0] s;
    logic [lpm_widthdist-1:0] sum;
    logic                     take;
    logic                     zero_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = WD >> (stage + SW'(1));
    assign sum       = take ? acc + s : acc;

    lpm_norm_stage #(
        .W  (lpm_width),
        .DW (lpm_widthdist)
    ) u_stage (
        .cur       (cur),
        .s         (s),
        .shifttype (ST),
        .nxt       (nxt),
        .take      (take)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            stage    <= '0;
            cur      <= '0;
            acc      <= '0;
            zero_r   <= 1'b0;
            result   <= '0;
            distance <= '0;
            zero     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cur    <= data;
                    acc    <= '0;
                    zero_r <= (data == '0);
                    stage  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    cur   <= nxt;
                    acc   <= sum;
                    stage <= stage + SW'(1);
                    // Outputs are captured only on the last stage, so they stay put otherwise
                    if (stage == SW'(L - 1)) begin
                        result   <= nxt;
                        distance <= (ST == LOGICAL && zero_r) ? WD : sum;
                        zero     <= zero_r;
                        state    <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpm_normalize.sv
// tb_lpm_normalize: scoreboard bench for LOGICAL and ARITHMETIC normalizer instances
module tb_lpm_normalize;

    localparam int L = 5;

    typedef struct {
        int          sel;
        logic [31:0] r;
        logic [5:0]  d;
        logic        z;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid[2];
    logic        in_ready[2];
    logic [31:0] data[2];
    logic        flush[2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [31:0] result[2];
    logic [5:0]  distance[2];
    logic        zero[2];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    lpm_normalize #(.lpm_width(32), .lpm_shifttype("LOGICAL")) u_log (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data(data[0]), .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .distance(distance[0]), .zero(zero[0])
    );

    lpm_normalize #(.lpm_width(32), .lpm_shifttype("ARITHMETIC")) u_ari (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data(data[1]), .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .distance(distance[1]), .zero(zero[1])
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: count leading zeros / redundant sign bits one bit at a time
    function automatic exp_t model(input int sel, input logic [31:0] d);
        exp_t e;
        int   n;
        n = 0;
        if (sel == 0) begin
            while (n < 32 && d[31-n] == 1'b0) n++;
        end else begin
            while (n < 31 && d[30-n] == d[31]) n++;
        end
        e.sel = sel;
        e.r   = (n >= 32) ? 32'h0 : d << n;
        e.d   = 6'(n);
        e.z   = (d == 32'h0);
        return e;
    endfunction

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (out_valid[i] && out_ready[i]) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_sel", i, e.sel);
                    chk("sb_result", result[i], e.r);
                    chk("sb_distance", distance[i], e.d);
                    chk("sb_zero", zero[i], e.z);
                end
            end
        end
    end

    task automatic send(input int sel, input logic [31:0] d);
        int n;
        n = 0;
        while (!in_ready[sel] && n < 20) begin @(posedge clock); #1; n++; end
        chk("in_ready_wait", in_ready[sel], 1);
        data[sel] = d;
        in_valid[sel] = 1;
        sb.push_back(model(sel, d));
        @(posedge clock); #1;
        in_valid[sel] = 0;
        chk("busy", in_ready[sel], 0);
        n = 0;
        while (!out_valid[sel] && n < 20) begin @(posedge clock); #1; n++; end
        chk("latency", n, L);
        if (out_ready[sel]) begin
            @(posedge clock); #1;
            chk("rdy_rise", in_ready[sel], 1);
        end
    endtask

    task automatic chk_reset(input int i);
        chk("rst_in_ready", in_ready[i], 1);
        chk("rst_out_valid", out_valid[i], 0);
        chk("rst_result", result[i], 0);
        chk("rst_distance", distance[i], 0);
        chk("rst_zero", zero[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset_n = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 0; data[i] = 0; flush[i] = 0; out_ready[i] = 1;
        end
        repeat (2) @(posedge clock);
        #1;
        chk_reset(0);
        chk_reset(1);
        reset_n = 1;
        @(posedge clock); #1;

        send(0, 32'h0000_1000);
        send(0, 32'h0000_0000);
        send(0, 32'h8000_0000);
        send(0, 32'h0000_0001);
        send(1, 32'hFFFF_F000);
        send(1, 32'h0000_0001);
        send(1, 32'hFFFF_FFFF);
        send(1, 32'h0000_0000);
        send(1, 32'h7FFF_FFFF);
        send(1, 32'h8000_0000);
        for (int k = 0; k < 8; k++) begin
            send(0, $urandom >> $urandom_range(31, 0));
            send(1, $urandom);
        end

        // Backpressure: result must sit still and a second request must be ignored
        out_ready[0] = 0;
        send(0, 32'h00F0_0000);
        e = model(0, 32'h00F0_0000);
        data[0] = 32'hDEAD_BEEF;
        in_valid[0] = 1;
        repeat (10) begin
            @(posedge clock); #1;
            chk("bp_valid", out_valid[0], 1);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_result", result[0], e.r);
            chk("bp_distance", distance[0], e.d);
        end
        in_valid[0] = 0;
        out_ready[0] = 1;
        @(posedge clock); #1;
        chk("bp_release_rdy", in_ready[0], 1);
        chk("bp_release_valid", out_valid[0], 0);

        // Flush in IDLE blocks the accept in the same cycle
        data[0] = 32'h5;
        in_valid[0] = 1;
        flush[0] = 1;
        @(posedge clock); #1;
        in_valid[0] = 0;
        flush[0] = 0;
        chk("flush_idle_rdy", in_ready[0], 1);

        // Flush in the second RUN cycle
        data[0] = 32'h1234;
        in_valid[0] = 1;
        @(posedge clock); #1;
        in_valid[0] = 0;
        @(posedge clock); #1;
        flush[0] = 1;
        @(posedge clock); #1;
        flush[0] = 0;
        chk("flush_run_rdy", in_ready[0], 1);
        repeat (8) begin
            chk("flush_no_valid", out_valid[0], 0);
            @(posedge clock); #1;
        end
        send(0, 32'h0000_0001);

        // Asynchronous reset mid-RUN
        data[1] = 32'h0000_00FF;
        in_valid[1] = 1;
        @(posedge clock); #1;
        in_valid[1] = 0;
        @(posedge clock); #1;
        reset_n = 0;
        #1;
        chk_reset(1);
        chk_reset(0);
        @(posedge clock); #1;
        reset_n = 1;
        repeat (8) begin
            @(posedge clock); #1;
            chk("rst_no_valid", out_valid[1], 0);
        end
        send(1, 32'h0000_00FF);

        repeat (3) @(posedge clock);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
